// File: rtl/circuit1_sched_ctrl_if.sv
// circuit1_sched_ctrl_if
// Groups the operand/handshake/result signals of circuit1_sched_ctrl.
//   start : request from the operand source
//   a,b,c : operands, DATAWIDTH bits
//   busy  : controller is not idle
//   done  : one-cycle completion pulse
//   x     : result f - d, 2*DATAWIDTH bits
//   z     : min-select of d and e, DATAWIDTH bits
// master = operand source / result consumer side, slave = controller side.
interface circuit1_sched_ctrl_if #(
    parameter int unsigned DATAWIDTH = 8
);
    logic                     start;
    logic [DATAWIDTH-1:0]     a;
    logic [DATAWIDTH-1:0]     b;
    logic [DATAWIDTH-1:0]     c;
    logic                     busy;
    logic                     done;
    logic [2*DATAWIDTH-1:0]   x;
    logic [DATAWIDTH-1:0]     z;

    modport master (
        output start, a, b, c,
        input  busy, done, x, z
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, x, z
    );
endinterface

// File: rtl/circuit1_sched_ctrl.sv
// circuit1_sched_ctrl
// Scheduled Circuit1 dataflow: d=a+b, e=a+c, g=(d>e), z=g?e:d, f=a*c, x=f-d.
// One shared adder/subtractor and one multiplier, sequenced by an FSM.
// Ports:
//   Clk : rising-edge clock
//   Rst : asynchronous active-high reset
//   bus : slave side of circuit1_sched_ctrl_if (start, a, b, c in;
//         busy, done, x, z out)
// Latency: start accepted at edge N, x/z update at edge N+4, done is high
// for the following cycle, controller is back in IDLE after edge N+5.
module circuit1_sched_ctrl #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    circuit1_sched_ctrl_if.slave  bus
);
    localparam int unsigned W2 = 2 * DATAWIDTH;

    typedef enum logic [2:0] {
        IDLE,
        S_ADD1,
        S_ADD2,
        S_CMPMUL,
        S_SUB,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATAWIDTH-1:0]   d_q, d_d, e_q, e_d;
    logic                   g_q, g_d;
    logic [W2-1:0]          f_q, f_d;
    logic [W2-1:0]          x_q, x_d;
    logic [DATAWIDTH-1:0]   z_q, z_d;

    // Shared ALU, operands and add/sub selected by state.
    logic [W2-1:0]          alu_a, alu_b, alu_y;
    logic                   alu_sub;

    always_comb begin
        alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        g_d     = g_q;
        f_d     = f_q;
        x_d     = x_q;
        z_d     = z_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.c;
                    state_d = S_ADD1;
                end
            end
            S_ADD1: begin
                alu_a   = {{DATAWIDTH{1'b0}}, a_q};
                alu_b   = {{DATAWIDTH{1'b0}}, b_q};
                d_d     = alu_y[DATAWIDTH-1:0];
                state_d = S_ADD2;
            end
            S_ADD2: begin
                alu_a   = {{DATAWIDTH{1'b0}}, a_q};
                alu_b   = {{DATAWIDTH{1'b0}}, c_q};
                e_d     = alu_y[DATAWIDTH-1:0];
                state_d = S_CMPMUL;
            end
            S_CMPMUL: begin
                g_d     = (d_q > e_q);
                f_d     = {{DATAWIDTH{1'b0}}, a_q} * {{DATAWIDTH{1'b0}}, c_q};
                state_d = S_SUB;
            end
            S_SUB: begin
                alu_a   = f_q;
                alu_b   = {{DATAWIDTH{1'b0}}, d_q};
                alu_sub = 1'b1;
                x_d     = alu_y;
                // Min-select taken from the stored compare bit; d and e are
                // stable since S_CMPMUL, so this equals latching it a cycle early.
                z_d     = g_q ? e_q : d_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            g_q     <= 1'b0;
            f_q     <= '0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            g_q     <= g_d;
            f_q     <= f_d;
            x_q     <= x_d;
            z_q     <= z_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.x    = x_q;
    assign bus.z    = z_q;
endmodule

// File: tb/tb_circuit1_sched_ctrl.sv
module tb_circuit1_sched_ctrl;
    localparam int unsigned DW = 8;

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_fail;

    circuit1_sched_ctrl_if #(.DATAWIDTH(DW)) bus ();

    circuit1_sched_ctrl #(.DATAWIDTH(DW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Launch one operation at a negedge and wait (bounded) for done.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                          output logic [15:0] xo, output logic [7:0] zo, output bit seen);
        seen = 1'b0;
        @(negedge Clk);
        bus.a = ia; bus.b = ib; bus.c = ic; bus.start = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge Clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        xo = bus.x;
        zo = bus.z;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.x !== 16'd0 || bus.z !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b x=%0d z=%0d required 0 0 0 0",
                     bus.busy, bus.done, bus.x, bus.z);
        end
        Rst = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_timing();
        logic exp_busy, exp_done;
        @(negedge Clk);
        bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd5; bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            bus.start = 1'b0;
            exp_busy = (k <= 5);
            exp_done = (k == 5);
            n_checks++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL timing_k%0d: busy=%b done=%b required busy=%b done=%b",
                         k, bus.busy, bus.done, exp_busy, exp_done);
            end
            if (k == 5) begin
                n_checks++;
                if (bus.x !== 16'd8 || bus.z !== 8'd7) begin
                    n_fail++;
                    $display("FAIL basic_result: x=%0d z=%0d required x=8 z=7", bus.x, bus.z);
                end
            end
        end
        n_checks++;
        if (bus.x !== 16'd8 || bus.z !== 8'd7) begin
            n_fail++;
            $display("FAIL result_hold: x=%0d z=%0d required x=8 z=7", bus.x, bus.z);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  va [5] = '{8'd10, 8'd200, 8'd1, 8'd255, 8'd0};
        logic [7:0]  vb [5] = '{8'd20, 8'd100, 8'd9, 8'd255, 8'd0};
        logic [7:0]  vc [5] = '{8'd5,  8'd10,  8'd2, 8'd255, 8'd0};
        logic [15:0] ex [5] = '{16'd20, 16'd1956, 16'hFFF8, 16'd64771, 16'd0};
        logic [7:0]  ez [5] = '{8'd15, 8'd44, 8'd3, 8'd254, 8'd0};
        logic [15:0] xo;
        logic [7:0]  zo;
        bit          seen;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], xo, zo, seen);
            n_checks++;
            if (!seen || xo !== ex[i] || zo !== ez[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: done_seen=%0d x=%0d z=%0d required done_seen=1 x=%0d z=%0d",
                         i, seen, xo, zo, ex[i], ez[i]);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd5; bus.start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge Clk);
            if (k == 2) begin
                bus.a = 8'd10; bus.b = 8'd20; bus.c = 8'd5;
            end
            if (k == 5) begin
                n_checks++;
                if (bus.done !== 1'b1 || bus.x !== 16'd8 || bus.z !== 8'd7) begin
                    n_fail++;
                    $display("FAIL b2b_first: done=%b x=%0d z=%0d required done=1 x=8 z=7",
                             bus.done, bus.x, bus.z);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_gap: busy=%b required 0", bus.busy);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_reaccept: busy=%b required 1", bus.busy);
                end
                bus.start = 1'b0;
            end
            if (k == 8) bus.start = 1'b1;
            if (k == 9) bus.start = 1'b0;
            if (k == 11) begin
                n_checks++;
                if (bus.done !== 1'b1 || bus.x !== 16'd20 || bus.z !== 8'd15) begin
                    n_fail++;
                    $display("FAIL b2b_second: done=%b x=%0d z=%0d required done=1 x=20 z=15",
                             bus.done, bus.x, bus.z);
                end
            end
            if (k == 13) begin
                n_checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_start_ignored: busy=%b done=%b required 0 0",
                             bus.busy, bus.done);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] xo;
        logic [7:0]  zo;
        bit          seen;
        bit          spurious;
        @(negedge Clk);
        bus.a = 8'd200; bus.b = 8'd100; bus.c = 8'd10; bus.start = 1'b1;
        @(negedge Clk); bus.start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);   // state is S_CMPMUL here
        Rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.x !== 16'd0 || bus.z !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_abort: busy=%b done=%b x=%0d z=%0d required 0 0 0 0",
                     bus.busy, bus.done, bus.x, bus.z);
        end
        @(negedge Clk);
        Rst = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL no_done_after_abort: done or busy asserted, required both 0");
        end
        run_op(8'd10, 8'd20, 8'd5, xo, zo, seen);
        n_checks++;
        if (!seen || xo !== 16'd20 || zo !== 8'd15) begin
            n_fail++;
            $display("FAIL post_reset_op: done_seen=%0d x=%0d z=%0d required done_seen=1 x=20 z=15",
                     seen, xo, zo);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst      = 1'b1;
        test_reset();
        test_timing();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/circuit1_sched_ctrl.md
Name: circuit1_sched_ctrl

Overview:
Multi-cycle scheduled implementation of the Circuit1 dataflow:
- d = a+b, e = a+c
- g = (d > e)
- z = g ? e : d
- f = a*c
- x = f − d

One shared adder/subtractor and one multiplier are sequenced by an FSM under a start/busy/done handshake. It replaces the fully parallel datapath where area matters, and sits between an operand source and a result consumer.

Parameters:
DATAWIDTH, 8, width of operands a, b, c and of intermediates d, e, z; x, f are 2*DATAWIDTH

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  DATAWIDTH  operand, captured at accepted start
b  input  DATAWIDTH  operand, captured at accepted start
c  input  DATAWIDTH  operand, captured at accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, high only in DONE
x  output  2*DATAWIDTH  registered result f − d
z  output  DATAWIDTH  registered result min-select of d, e

Behaviour:
- Reset (Rst=1, asynchronous): state=IDLE; busy=0, done=0, x=0, z=0; internal a_r, b_r, c_r, d, e, f, g cleared. Reset mid-operation aborts the operation: no done pulse, outputs cleared.
- States and per-edge actions:
  - IDLE: start=1 → latch a, b, c into a_r, b_r, c_r; go S_ADD1. start=0 → stay.
  - S_ADD1: shared ALU adds: d <= a_r+b_r, truncated to DATAWIDTH (mod 2^DATAWIDTH); go S_ADD2.
  - S_ADD2: shared ALU adds: e <= a_r+c_r, truncated; go S_CMPMUL.
  - S_CMPMUL: g <= (d > e), unsigned compare; z_int <= (d > e) ? e : d; f <= a_r*c_r, full 2*DATAWIDTH product, unsigned; go S_SUB.
  - S_SUB: shared ALU subtracts: x <= f − {0,d}, mod 2^(2*DATAWIDTH), so negative results wrap; z <= z_int in the same edge; go DONE.
  - DONE: done=1 for exactly one cycle; go IDLE unconditionally.
- Timing: start accepted at edge N → x and z update at edge N+4 → done high in the cycle after edge N+4 → IDLE after edge N+5.
- Minimum spacing between accepted starts is 6 cycles. A start held high continuously is re-accepted at the first IDLE edge.
- start in any state other than IDLE is ignored; a/b/c changes after capture do not affect the result.
- x and z hold their values until the next S_SUB edge or reset. Both update on the same edge and are valid from the done cycle onward.
- Shared ALU mux selects operands and add/sub by state; its output is don't-care in IDLE and DONE.
- busy = (state != IDLE); done = (state == DONE); both decoded from the state register, glitch-free.

Test Plan:
- Reset, then a=3, b=4, c=5, pulse start → done exactly 5 cycles after the start edge; x=8, z=7, busy high for 5 cycles.
- a=10, b=20, c=5 → d=30, e=15, g=1 → z=15, x=50−30=20.
- a=200, b=100, c=10 → d=44 (wrap), e=210 → z=44, x=2000−44=1956.
- a=1, b=9, c=2 → d=10, e=3, f=2 → z=3, x=0xFFF8 (negative wrap).
- start held high across two operations with a/b/c changed mid-operation (3,4,5 → 10,20,5 during S_ADD2):
  - first result is x=8, z=7, unaffected by the change;
  - second operation is accepted at the IDLE edge and yields x=20, z=15;
  - start pulses during busy are ignored.
- Assert Rst during S_CMPMUL → busy, done, x, z = 0 immediately (asynchronous); no done pulse; the next start completes normally.
